// File: rtl/alt_vipitc121_mode_pkg.sv
// ============================================================================
// Module  : alt_vipitc121_mode_pkg
// Brief   : Shared state encodings and helpers for the ITC mode sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alt_vipitc121_mode_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_SWITCH  = 2'd2;
    localparam logic [1:0] ST_SETTLE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_PENDING = ST_PENDING,
        S_SWITCH  = ST_SWITCH,
        S_SETTLE  = ST_SETTLE
    } mode_state_e;

    // A zero-length settle still needs a one-bit counter to stay legal.
    function automatic int settle_cnt_width(input int settle_cycles);
        return (settle_cycles > 0) ? $clog2(settle_cycles + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alt_vipitc121_onehot_priority_encoder.sv
// ============================================================================
// Module  : alt_vipitc121_onehot_priority_encoder
// Brief   : Lowest-set-bit index of a request vector plus zero/multi-hot flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alt_vipitc121_onehot_priority_encoder #(
    parameter int NO_OF_MODES      = 3,
    parameter int LOG2_NO_OF_MODES = 2
) (
    input  logic [NO_OF_MODES-1:0]      req_i,
    output logic [LOG2_NO_OF_MODES-1:0] idx_o,
    output logic                        zero_o,
    output logic                        multi_o
);

    always_comb begin
        idx_o = '0;
        // Descending scan so the lowest set bit is the last to write.
        for (int i = NO_OF_MODES - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = LOG2_NO_OF_MODES'(i);
            end
        end
    end

    assign zero_o  = ~|req_i;
    assign multi_o = |(req_i & (req_i - NO_OF_MODES'(1)));

endmodule

`default_nettype wire

// File: rtl/alt_vipitc121_mode_sequencer.sv
// ============================================================================
// Module  : alt_vipitc121_mode_sequencer
// Brief   : Accepts one-hot mode requests and applies them at frame boundaries.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alt_vipitc121_mode_sequencer #(
    parameter int NO_OF_MODES      = 3,
    parameter int LOG2_NO_OF_MODES = 2,
    parameter int STRICT_ONE_HOT   = 1,
    parameter int SETTLE_CYCLES    = 4,
    parameter int DEFAULT_MODE     = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NO_OF_MODES-1:0]      mode_req,
    input  logic                        mode_req_valid,
    output logic                        mode_req_ready,
    input  logic                        frame_boundary,
    input  logic                        clear_error,
    output logic [LOG2_NO_OF_MODES-1:0] mode_binary,
    output logic                        mode_change,
    output logic                        mode_pending,
    output logic                        mode_error
);

    import alt_vipitc121_mode_pkg::*;

    localparam int                          CNT_W    = settle_cnt_width(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]            CNT_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [LOG2_NO_OF_MODES-1:0] RST_MODE = LOG2_NO_OF_MODES'(DEFAULT_MODE);

    mode_state_e                 state_q, state_d;
    logic [LOG2_NO_OF_MODES-1:0] mode_q, mode_d;
    logic [LOG2_NO_OF_MODES-1:0] target_q, target_d;
    logic                        change_q, change_d;
    logic                        error_q, error_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    logic [LOG2_NO_OF_MODES-1:0] enc_idx;
    logic                        enc_zero;
    logic                        enc_multi;
    logic [LOG2_NO_OF_MODES-1:0] req_enc;
    logic                        ready;
    logic                        accept;
    logic                        reject;
    logic                        take;

    alt_vipitc121_onehot_priority_encoder #(
        .NO_OF_MODES      (NO_OF_MODES),
        .LOG2_NO_OF_MODES (LOG2_NO_OF_MODES)
    ) u_encoder (
        .req_i   (mode_req),
        .idx_o   (enc_idx),
        .zero_o  (enc_zero),
        .multi_o (enc_multi)
    );

    assign req_enc = enc_zero ? '0 : enc_idx + LOG2_NO_OF_MODES'(1);
    assign ready   = (state_q == S_IDLE) || ((state_q == S_PENDING) && !frame_boundary);
    assign accept  = mode_req_valid && ready;
    assign reject  = accept && enc_multi && (STRICT_ONE_HOT != 0);
    assign take    = accept && !reject;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        target_d = target_q;
        change_d = 1'b0;
        cnt_d    = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                // A boundary in this same cycle is deliberately not honoured.
                if (take && (req_enc != mode_q)) begin
                    target_d = req_enc;
                    state_d  = S_PENDING;
                end
            end
            S_PENDING: begin
                if (frame_boundary) begin
                    state_d = S_SWITCH;
                end else if (take) begin
                    target_d = req_enc;
                    if (req_enc == mode_q) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_SWITCH: begin
                mode_d   = target_q;
                change_d = 1'b1;
                cnt_d    = '0;
                state_d  = (SETTLE_CYCLES > 0) ? S_SETTLE : S_IDLE;
            end
            S_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A rejection in the same cycle as clear_error keeps the flag set.
    always_comb begin
        error_d = clear_error ? 1'b0 : error_q;
        if (reject) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= RST_MODE;
            target_q <= RST_MODE;
            change_q <= 1'b0;
            error_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            target_q <= target_d;
            change_q <= change_d;
            error_q  <= error_d;
            cnt_q    <= cnt_d;
        end
    end

    assign mode_req_ready = ready;
    assign mode_binary    = mode_q;
    assign mode_change    = change_q;
    assign mode_pending   = (state_q == S_PENDING);
    assign mode_error     = error_q;

endmodule

`default_nettype wire

// File: tb/tb_alt_vipitc121_mode_sequencer.sv
// ============================================================================
// Module  : tb_alt_vipitc121_mode_sequencer
// Brief   : Directed self-checking bench with a mode-change scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alt_vipitc121_mode_sequencer;

    logic       clk;
    logic       rst_n;
    logic [2:0] mode_req;
    logic       mode_req_valid;
    logic       mode_req_ready;
    logic       frame_boundary;
    logic       clear_error;
    logic [1:0] mode_binary;
    logic       mode_change;
    logic       mode_pending;
    logic       mode_error;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] sb_q[$];

    alt_vipitc121_mode_sequencer #(
        .NO_OF_MODES      (3),
        .LOG2_NO_OF_MODES (2),
        .STRICT_ONE_HOT   (1),
        .SETTLE_CYCLES    (4),
        .DEFAULT_MODE     (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mode_req       (mode_req),
        .mode_req_valid (mode_req_valid),
        .mode_req_ready (mode_req_ready),
        .frame_boundary (frame_boundary),
        .clear_error    (clear_error),
        .mode_binary    (mode_binary),
        .mode_change    (mode_change),
        .mode_pending   (mode_pending),
        .mode_error     (mode_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] m);
        mode_req       = m;
        mode_req_valid = 1'b1;
        cyc();
        mode_req_valid = 1'b0;
        mode_req       = 3'b000;
    endtask

    task automatic boundary(input bit expect_switch, input logic [1:0] exp_mode);
        if (expect_switch) sb_q.push_back(exp_mode);
        frame_boundary = 1'b1;
        cyc();
        frame_boundary = 1'b0;
    endtask

    // Every mode_change pulse must match the oldest queued switch target.
    always @(posedge clk) begin
        #2;
        if (mode_change === 1'b1) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_change observed=%0h expected=no_pulse", mode_binary);
            end
            if (sb_q.size() != 0) begin
                logic [1:0] exp_mode;
                exp_mode = sb_q.pop_front();
                checks++;
                assert (mode_binary === exp_mode) else begin
                    errors++;
                    $error("FAIL sb_mode observed=%0h expected=%0h", mode_binary, exp_mode);
                end
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        mode_req       = 3'b000;
        mode_req_valid = 1'b0;
        frame_boundary = 1'b0;
        clear_error    = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;

        chk("rst_mode",    32'(mode_binary),    32'd1);
        chk("rst_ready",   32'(mode_req_ready), 32'd1);
        chk("rst_error",   32'(mode_error),     32'd0);
        chk("rst_pending", 32'(mode_pending),   32'd0);
        chk("rst_change",  32'(mode_change),    32'd0);

        // Request then cancel by re-requesting the current mode.
        send(3'b010);
        chk("cancel_pend1", 32'(mode_pending), 32'd1);
        send(3'b001);
        chk("cancel_pend0", 32'(mode_pending), 32'd0);
        boundary(1'b0, 2'd0);
        cyc();
        cyc();
        chk("cancel_mode", 32'(mode_binary), 32'd1);

        // Normal switch to mode 3 with boundary five cycles after accept.
        send(3'b100);
        for (int i = 0; i < 4; i++) begin
            chk("pend_wait", 32'(mode_pending), 32'd1);
            cyc();
        end
        chk("pend_ready", 32'(mode_req_ready), 32'd1);
        frame_boundary = 1'b1;
        #1;
        chk("fb_ready", 32'(mode_req_ready), 32'd0);
        sb_q.push_back(2'd3);
        cyc();
        frame_boundary = 1'b0;
        chk("sw_pending", 32'(mode_pending),   32'd0);
        chk("sw_ready",   32'(mode_req_ready), 32'd0);
        chk("sw_mode",    32'(mode_binary),    32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("settle_ready",  32'(mode_req_ready), 32'd0);
            chk("settle_mode",   32'(mode_binary),    32'd3);
            chk("settle_change", 32'(mode_change),    (i == 0) ? 32'd1 : 32'd0);
        end
        cyc();
        chk("post_ready", 32'(mode_req_ready), 32'd1);

        // Multi-hot rejection and error clearing.
        send(3'b011);
        chk("mh_error",   32'(mode_error),   32'd1);
        chk("mh_mode",    32'(mode_binary),  32'd3);
        chk("mh_pending", 32'(mode_pending), 32'd0);
        clear_error = 1'b1;
        send(3'b110);
        clear_error = 1'b0;
        chk("clr_vs_reject", 32'(mode_error), 32'd1);
        clear_error = 1'b1;
        cyc();
        clear_error = 1'b0;
        chk("clr_error", 32'(mode_error), 32'd0);

        // Disable request coinciding with a boundary waits for the next one.
        frame_boundary = 1'b1;
        send(3'b000);
        frame_boundary = 1'b0;
        chk("same_fb_pend", 32'(mode_pending), 32'd1);
        cyc();
        cyc();
        chk("same_fb_mode", 32'(mode_binary), 32'd3);
        boundary(1'b1, 2'd0);
        cyc();
        chk("dis_mode", 32'(mode_binary), 32'd0);
        repeat (5) cyc();
        chk("dis_ready", 32'(mode_req_ready), 32'd1);

        // Reset during SETTLE.
        send(3'b100);
        boundary(1'b1, 2'd3);
        cyc();
        cyc();
        chk("pre_rst_mode", 32'(mode_binary), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("rst_settle_mode",   32'(mode_binary),    32'd1);
        chk("rst_settle_change", 32'(mode_change),    32'd0);
        chk("rst_settle_ready",  32'(mode_req_ready), 32'd1);
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        chk("rel_settle_mode", 32'(mode_binary), 32'd1);

        // Reset during PENDING.
        send(3'b010);
        chk("pend_before_rst", 32'(mode_pending), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_pend_pending", 32'(mode_pending), 32'd0);
        chk("rst_pend_mode",    32'(mode_binary),  32'd1);
        cyc();
        rst_n = 1'b1;
        chk("rel_ready", 32'(mode_req_ready), 32'd1);
        boundary(1'b0, 2'd0);
        repeat (3) cyc();
        chk("rel_pend_mode", 32'(mode_binary), 32'd1);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
